// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the decode stage: opcodes, funct codes, ALU
// operations and the decoded control bundle carried into ID/EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_NOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_LUI  = 4'd7
  } alu_op_t;

  // Everything ID hands to EX that is derived from the instruction word alone.
  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        beq;
    logic        bne;
    alu_op_t     alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
  } ctrl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Signal bundle around the decode stage: IF/ID input, register-file ports,
// writeback bypass, flush, and the ID/EX register outputs.
interface id_stage_if;
  import mips_pkg::*;

  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [4:0]  rf_addr_a;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_a;
  logic [31:0] rf_data_b;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        stall;
  logic        illegal;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_alu_src;
  logic        ex_beq;
  logic        ex_bne;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_pc4;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;

  // Surrounding pipeline's view.
  modport master (
    output ifid_valid, ifid_instr, ifid_pc4, rf_data_a, rf_data_b,
           wb_we, wb_addr, wb_data, ex_flush,
    input  rf_addr_a, rf_addr_b, stall, illegal,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_beq, ex_bne, ex_alu_op, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest
  );

  // Decode stage's view.
  modport slave (
    input  ifid_valid, ifid_instr, ifid_pc4, rf_data_a, rf_data_b,
           wb_we, wb_addr, wb_data, ex_flush,
    output rf_addr_a, rf_addr_b, stall, illegal,
           ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_beq, ex_bne, ex_alu_op, ex_pc4, ex_rs_data,
           ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest
  );
endinterface

// File: rtl/id_decoder.sv
// Purely combinational MIPS decoder: control bundle, immediate, destination,
// illegal flag and which source registers the instruction actually reads.
module id_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        use_rs,
  output logic        use_rt
);
  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    ctrl      = '0;
    ctrl.rs   = instr[25:21];
    ctrl.rt   = instr[20:16];
    ctrl.imm  = sign_ext16(instr[15:0]);
    illegal   = 1'b0;
    use_rs    = 1'b1;
    use_rt    = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.dest      = instr[15:11];
        use_rt         = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:          ctrl.alu_op = ALU_AND;
          FN_OR:           ctrl.alu_op = ALU_OR;
          FN_NOR:          ctrl.alu_op = ALU_NOR;
          FN_SLT:          ctrl.alu_op = ALU_SLT;
          FN_SLTU:         ctrl.alu_op = ALU_SLTU;
          default: begin
            illegal        = 1'b1;
            ctrl.reg_write = 1'b0;
            ctrl.dest      = '0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.dest      = instr[20:16];
      end
      OP_SLTI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_SLT;
        ctrl.dest      = instr[20:16];
      end
      OP_ANDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_AND;
        ctrl.dest      = instr[20:16];
        ctrl.imm       = {16'h0000, instr[15:0]};
      end
      OP_ORI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OR;
        ctrl.dest      = instr[20:16];
        ctrl.imm       = {16'h0000, instr[15:0]};
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_LUI;
        ctrl.dest      = instr[20:16];
        ctrl.imm       = {instr[15:0], 16'h0000};
        use_rs         = 1'b0;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.dest       = instr[20:16];
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        use_rt         = 1'b1;
      end
      OP_BEQ: begin
        ctrl.beq    = 1'b1;
        ctrl.alu_op = ALU_SUB;
        use_rt      = 1'b1;
      end
      OP_BNE: begin
        ctrl.bne    = 1'b1;
        ctrl.alu_op = ALU_SUB;
        use_rt      = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, writeback bypass, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  id_stage_if.slave  bus
);
  ctrl_t       dec_ctrl;
  logic        dec_illegal;
  logic        use_rs;
  logic        use_rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hazard;
  logic        bubble;
  ctrl_t       ctrl_d;

  ctrl_t       ctrl_q;
  logic        valid_q;
  logic        illegal_q;
  logic [31:0] pc4_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;

  id_decoder u_decoder (
    .instr   (bus.ifid_instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .use_rs  (use_rs),
    .use_rt  (use_rt)
  );

  assign bus.rf_addr_a = dec_ctrl.rs;
  assign bus.rf_addr_b = dec_ctrl.rt;

  // The register file writes at the edge but reads combinationally, so a
  // same-cycle writeback must be forwarded here.
  always_comb begin
    rs_data = bus.rf_data_a;
    rt_data = bus.rf_data_b;
    if (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == dec_ctrl.rs))
      rs_data = bus.wb_data;
    if (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == dec_ctrl.rt))
      rt_data = bus.wb_data;
  end

  always_comb begin
    hazard = 1'b0;
    if (valid_q && ctrl_q.mem_read && (ctrl_q.dest != '0))
      hazard = (use_rs && (ctrl_q.dest == dec_ctrl.rs)) ||
               (use_rt && (ctrl_q.dest == dec_ctrl.rt));
  end

  assign bus.stall = hazard && !bus.ex_flush;
  assign bubble    = bus.ex_flush || hazard || !bus.ifid_valid || dec_illegal;

  // Bubbles only clear control; register numbers and data ride along unused.
  always_comb begin
    ctrl_d = dec_ctrl;
    if (bubble) begin
      ctrl_d.reg_write  = 1'b0;
      ctrl_d.mem_read   = 1'b0;
      ctrl_d.mem_write  = 1'b0;
      ctrl_d.mem_to_reg = 1'b0;
      ctrl_d.alu_src    = 1'b0;
      ctrl_d.beq        = 1'b0;
      ctrl_d.bne        = 1'b0;
      ctrl_d.alu_op     = ALU_ADD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= !bubble;
      illegal_q <= bus.ifid_valid && dec_illegal && !bus.ex_flush && !hazard;
      pc4_q     <= bus.ifid_pc4;
      rs_data_q <= rs_data;
      rt_data_q <= rt_data;
    end
  end

  assign bus.illegal       = illegal_q;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_beq        = ctrl_q.beq;
  assign bus.ex_bne        = ctrl_q.bne;
  assign bus.ex_alu_op     = ctrl_q.alu_op;
  assign bus.ex_pc4        = pc4_q;
  assign bus.ex_rs_data    = rs_data_q;
  assign bus.ex_rt_data    = rt_data_q;
  assign bus.ex_imm        = ctrl_q.imm;
  assign bus.ex_rs         = ctrl_q.rs;
  assign bus.ex_rt         = ctrl_q.rt;
  assign bus.ex_dest       = ctrl_q.dest;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against a table-driven instruction model.
module tb_id_stage;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] alu;
    bit rw, mr, mw, m2r, src, bq, bn, urs, urt;
    int ext;   // 0 sign, 1 zero, 2 upper
    int dst;   // 0 none, 1 rt, 2 rd
  } ent_t;

  ent_t tbl[20];

  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;

  id_stage_if bus();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference ID/EX contents
  bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_src, m_bq, m_bn, m_ill;
  logic [3:0]  m_alu;
  logic [31:0] m_pc4, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_dest;
  bit          exp_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] alu,
                              input bit rw, input bit mr, input bit mw, input bit m2r, input bit src,
                              input bit bq, input bit bn, input bit urs, input bit urt,
                              input int ext, input int dst);
    ent_t e;
    e.op = op; e.fn = fn; e.alu = alu; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
    e.src = src; e.bq = bq; e.bn = bn; e.urs = urs; e.urt = urt; e.ext = ext; e.dst = dst;
    return e;
  endfunction

  function automatic int find(input logic [31:0] ins);
    for (int i = 0; i < 20; i++)
      if (tbl[i].op == ins[31:26] && (ins[31:26] != 6'h00 || tbl[i].fn == ins[5:0]))
        return i;
    return -1;
  endfunction

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_m2r, m_src, m_bq, m_bn, m_ill} = '0;
    m_alu = '0; m_pc4 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_dest = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {23'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                        bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_beq, bus.ex_bne, bus.illegal}, 32'd0);
    chk({tag, "_alu"}, {28'd0, bus.ex_alu_op}, 32'd0);
    chk({tag, "_pc4"}, bus.ex_pc4, 32'd0);
    chk({tag, "_rsd"}, bus.ex_rs_data, 32'd0);
    chk({tag, "_rtd"}, bus.ex_rt_data, 32'd0);
    chk({tag, "_imm"}, bus.ex_imm, 32'd0);
    chk({tag, "_regs"}, {17'd0, bus.ex_rs, bus.ex_rt, bus.ex_dest}, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
  endtask

  // Present one instruction for one cycle, check combinational outputs, then
  // advance the reference model over the clock edge and check ID/EX.
  task automatic step(input bit v, input logic [31:0] ins, input bit fl,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] ra, input logic [31:0] rb);
    int k;
    logic [4:0] rs, rt, rd;
    logic [31:0] pc4, rsd, rtd, a, b;
    bit bubble, urs, urt;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a = (rs == 0) ? 32'd0 : ra;
    b = (rt == 0) ? 32'd0 : rb;
    pc4 = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    bus.ifid_valid = v; bus.ifid_instr = ins; bus.ifid_pc4 = pc4;
    bus.rf_data_a = a; bus.rf_data_b = b;
    bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd; bus.ex_flush = fl;
    #2;
    k = find(ins);
    urs = (k < 0) ? 1'b1 : tbl[k].urs;
    urt = (k < 0) ? 1'b0 : tbl[k].urt;
    exp_stall = !fl && m_valid && m_mr && m_dest != 0 &&
                ((urs && m_dest == rs) || (urt && m_dest == rt));
    chk("rf_addr_a", {27'd0, bus.rf_addr_a}, {27'd0, rs});
    chk("rf_addr_b", {27'd0, bus.rf_addr_b}, {27'd0, rt});
    chk("stall", {31'd0, bus.stall}, {31'd0, exp_stall});
    rsd = (we && wa != 0 && wa == rs) ? wd : a;
    rtd = (we && wa != 0 && wa == rt) ? wd : b;
    bubble = fl || exp_stall || !v || k < 0;
    m_ill = v && k < 0 && !fl && !exp_stall;
    m_valid = !bubble;
    if (bubble) begin
      {m_rw, m_mr, m_mw, m_m2r, m_src, m_bq, m_bn} = '0;
    end else begin
      m_rw = tbl[k].rw; m_mr = tbl[k].mr; m_mw = tbl[k].mw; m_m2r = tbl[k].m2r;
      m_src = tbl[k].src; m_bq = tbl[k].bq; m_bn = tbl[k].bn; m_alu = tbl[k].alu;
      m_pc4 = pc4; m_rsd = rsd; m_rtd = rtd; m_rs = rs; m_rt = rt;
      case (tbl[k].ext)
        1: m_imm = {16'd0, ins[15:0]};
        2: m_imm = {ins[15:0], 16'd0};
        default: m_imm = {{16{ins[15]}}, ins[15:0]};
      endcase
      m_dest = (tbl[k].dst == 1) ? rt : (tbl[k].dst == 2) ? rd : 5'd0;
    end
    @(posedge clk);
    #1;
    chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
    chk("ex_ctl", {25'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
                   bus.ex_alu_src, bus.ex_beq, bus.ex_bne},
                  {25'd0, m_rw, m_mr, m_mw, m_m2r, m_src, m_bq, m_bn});
    chk("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
    if (m_valid) begin
      chk("ex_alu_op", {28'd0, bus.ex_alu_op}, {28'd0, m_alu});
      chk("ex_pc4", bus.ex_pc4, m_pc4);
      chk("ex_rs_data", bus.ex_rs_data, m_rsd);
      chk("ex_rt_data", bus.ex_rt_data, m_rtd);
      chk("ex_imm", bus.ex_imm, m_imm);
      chk("ex_regs", {17'd0, bus.ex_rs, bus.ex_rt, bus.ex_dest}, {17'd0, m_rs, m_rt, m_dest});
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] bad_op[7];
    logic [5:0] bad_fn[5];
    logic [4:0] rs, rt, rd;
    int k;
    bad_op = '{6'h3F, 6'h02, 6'h03, 6'h10, 6'h20, 6'h0B, 6'h0E};
    bad_fn = '{6'h00, 6'h08, 6'h26, 6'h2C, 6'h3F};
    rs = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) begin
      // Illegal words keep rs/rt at r0 so they can never meet a load-use hazard
      if ($urandom_range(0, 1) == 0)
        return {bad_op[$urandom_range(0, 6)], 10'd0, 16'($urandom)};
      return {6'h00, 10'd0, rd, 5'd0, bad_fn[$urandom_range(0, 4)]};
    end
    k = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 19);
    if (tbl[k].op == 6'h00)
      return {6'h00, rs, rt, rd, 5'($urandom), tbl[k].fn};
    return {tbl[k].op, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    logic [31:0] ins;
    tbl[0]  = mk(6'h00, 6'h20, 4'd0, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[1]  = mk(6'h00, 6'h21, 4'd0, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[2]  = mk(6'h00, 6'h22, 4'd1, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[3]  = mk(6'h00, 6'h23, 4'd1, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[4]  = mk(6'h00, 6'h24, 4'd2, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[5]  = mk(6'h00, 6'h25, 4'd3, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[6]  = mk(6'h00, 6'h27, 4'd4, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[7]  = mk(6'h00, 6'h2A, 4'd5, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[8]  = mk(6'h00, 6'h2B, 4'd6, 1,0,0,0,0,0,0, 1,1, 0, 2);
    tbl[9]  = mk(6'h08, 6'h00, 4'd0, 1,0,0,0,1,0,0, 1,0, 0, 1);
    tbl[10] = mk(6'h09, 6'h00, 4'd0, 1,0,0,0,1,0,0, 1,0, 0, 1);
    tbl[11] = mk(6'h0C, 6'h00, 4'd2, 1,0,0,0,1,0,0, 1,0, 1, 1);
    tbl[12] = mk(6'h0D, 6'h00, 4'd3, 1,0,0,0,1,0,0, 1,0, 1, 1);
    tbl[13] = mk(6'h0A, 6'h00, 4'd5, 1,0,0,0,1,0,0, 1,0, 0, 1);
    tbl[14] = mk(6'h0F, 6'h00, 4'd7, 1,0,0,0,1,0,0, 0,0, 2, 1);
    tbl[15] = mk(6'h23, 6'h00, 4'd0, 1,1,0,1,1,0,0, 1,0, 0, 1);
    tbl[16] = mk(6'h2B, 6'h00, 4'd0, 0,0,1,0,1,0,0, 1,1, 0, 0);
    tbl[17] = mk(6'h04, 6'h00, 4'd1, 0,0,0,0,0,1,0, 1,1, 0, 0);
    tbl[18] = mk(6'h05, 6'h00, 4'd1, 0,0,0,0,0,0,1, 1,1, 0, 0);
    tbl[19] = mk(6'h00, 6'h25, 4'd3, 1,0,0,0,0,0,0, 1,1, 0, 2);

    bus.ifid_valid = 0; bus.ifid_instr = '0; bus.ifid_pc4 = '0;
    bus.rf_data_a = '0; bus.rf_data_b = '0; bus.wb_we = 0; bus.wb_addr = '0;
    bus.wb_data = '0; bus.ex_flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 0;

    // addi $t1,$t0,-4
    step(1, 32'h2109FFFC, 0, 0, 5'd0, 32'd0, 32'h11, 32'h22);
    chk("addi_imm", bus.ex_imm, 32'hFFFFFFFC);
    chk("addi_dest", {27'd0, bus.ex_dest}, 32'd9);
    chk("addi_alu", {28'd0, bus.ex_alu_op}, 32'd0);
    // ori $t1,$t0,0x8000
    step(1, 32'h35098000, 0, 0, 5'd0, 32'd0, 32'h11, 32'h22);
    chk("ori_imm", bus.ex_imm, 32'h00008000);
    // Writeback bypass on rs, then the same with wb_addr=0
    step(1, 32'h21090001, 0, 1, 5'd8, 32'h1234, 32'd0, 32'd0);
    chk("bypass_rs", bus.ex_rs_data, 32'h1234);
    step(1, 32'h21090001, 0, 1, 5'd0, 32'h1234, 32'd0, 32'd0);
    chk("bypass_r0", bus.ex_rs_data, 32'd0);
    // lw $8,0($9) ; add $10,$8,$11
    step(1, 32'h8D280000, 0, 0, 5'd0, 32'd0, 32'h40, 32'h0);
    step(1, 32'h010B5020, 0, 0, 5'd0, 32'd0, 32'h5, 32'h6);
    chk("lu_stall_hit", {31'd0, exp_stall}, 32'd1);
    chk("lu_bubble", {31'd0, bus.ex_valid}, 32'd0);
    step(1, 32'h010B5020, 0, 0, 5'd0, 32'd0, 32'h5, 32'h6);
    chk("lu_issue_dest", {27'd0, bus.ex_dest}, 32'd10);
    // lw then lui $8 : rt of lui is not a source
    step(1, 32'h8D280000, 0, 0, 5'd0, 32'd0, 32'h40, 32'h0);
    step(1, 32'h3C081234, 0, 0, 5'd0, 32'd0, 32'h0, 32'h7);
    chk("lui_no_stall_valid", {31'd0, bus.ex_valid}, 32'd1);
    // Flush beats load-use
    step(1, 32'h8D280000, 0, 0, 5'd0, 32'd0, 32'h40, 32'h0);
    step(1, 32'h010B5020, 1, 0, 5'd0, 32'd0, 32'h5, 32'h6);
    chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    // Illegal opcode 0x3F: pulse, then clear; suppressed by flush
    step(1, 32'hFC000000, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    chk("illegal_pulse", {31'd0, bus.illegal}, 32'd1);
    step(1, 32'h21090001, 0, 0, 5'd0, 32'd0, 32'h3, 32'h0);
    chk("illegal_end", {31'd0, bus.illegal}, 32'd0);
    step(1, 32'hFC000000, 1, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    chk("illegal_flushed", {31'd0, bus.illegal}, 32'd0);

    // Asynchronous reset in the middle of a load-use stall
    step(1, 32'h8D280000, 0, 0, 5'd0, 32'd0, 32'h40, 32'h0);
    bus.ifid_instr = 32'h010B5020; bus.rf_data_a = 32'h5; bus.rf_data_b = 32'h6;
    #2;
    chk("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();

    for (int n = 0; n < 600; n++) begin
      ins = rand_instr();
      step($urandom_range(0, 9) != 0, ins, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
           $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
